// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file port controller.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int IDX_W    = 5;
    localparam int CNT_W    = 8;
    localparam int REG_ZERO = 0;

    // Read-side sequencing: wait for request, sample regfile, present operands
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Bus bundle between the port controller, its requester/consumer and the regfile.
interface regfile_port_ctrl_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int IDX_W  = regfile_pkg::IDX_W,
    parameter int CNT_W  = regfile_pkg::CNT_W
);
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [IDX_W-1:0]  rd_rs;
    logic [IDX_W-1:0]  rd_rt;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              wb_valid;
    logic [IDX_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic [IDX_W-1:0]  rf_read_reg1;
    logic [IDX_W-1:0]  rf_read_reg2;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic              rf_RegWrite;
    logic [IDX_W-1:0]  rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              err_r0_write;
    logic [CNT_W-1:0]  err_r0_count;

    // Controller side
    modport slave (
        input  rd_req_valid, rd_rs, rd_rt, op_ready, wb_valid, wb_reg, wb_data,
               rf_read_data1, rf_read_data2,
        output rd_req_ready, op_valid, op_a, op_b, rf_read_reg1, rf_read_reg2,
               rf_RegWrite, rf_write_reg, rf_write_data, err_r0_write, err_r0_count
    );

    // Requester / consumer / regfile side
    modport master (
        output rd_req_valid, rd_rs, rd_rt, op_ready, wb_valid, wb_reg, wb_data,
               rf_read_data1, rf_read_data2,
        input  rd_req_ready, op_valid, op_a, op_b, rf_read_reg1, rf_read_reg2,
               rf_RegWrite, rf_write_reg, rf_write_data, err_r0_write, err_r0_count
    );

endinterface

// File: rtl/regfile_port_ctrl_operand_bypass.sv
// Per-operand source select: r0 forces zero, a same-cycle write wins over the regfile.
module operand_bypass
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int IDX_W  = regfile_pkg::IDX_W
) (
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_reg,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_operand
);
    import regfile_pkg::*;

    // Priority: hardwired zero, then forwarded writeback, then regfile read
    always_comb begin
        o_operand = i_rf_data;
        if (i_idx == IDX_W'(REG_ZERO)) begin
            o_operand = '0;
        end else if (i_wr_en && (i_wr_reg == i_idx)) begin
            o_operand = i_wr_data;
        end
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: handshaked two-operand reads with write
// forwarding, combinational writeback pass-through and r0-write error tracking.
module regfile_port_ctrl
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int IDX_W  = regfile_pkg::IDX_W,
    parameter int CNT_W  = regfile_pkg::CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    regfile_port_ctrl_if.slave  bus
);
    import regfile_pkg::*;

    state_t            r_state;
    logic [IDX_W-1:0]  r_rs;
    logic [IDX_W-1:0]  r_rt;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic              r_op_valid;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_wr_en;
    logic              w_r0_write;
    logic              w_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_wr_en    = bus.wb_valid && (bus.wb_reg != IDX_W'(REG_ZERO));
    assign w_r0_write = bus.wb_valid && (bus.wb_reg == IDX_W'(REG_ZERO));
    assign w_ready    = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.op_ready);
    assign w_accept   = bus.rd_req_valid && w_ready;

    assign bus.rf_RegWrite   = w_wr_en;
    assign bus.rf_write_reg  = bus.wb_reg;
    assign bus.rf_write_data = bus.wb_data;
    assign bus.rf_read_reg1  = r_rs;
    assign bus.rf_read_reg2  = r_rt;
    assign bus.rd_req_ready  = w_ready;
    assign bus.op_valid      = r_op_valid;
    assign bus.op_a          = r_op_a;
    assign bus.op_b          = r_op_b;
    assign bus.err_r0_write  = r_err;
    assign bus.err_r0_count  = r_cnt;

    operand_bypass #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_byp_a (
        .i_idx     (r_rs),
        .i_rf_data (bus.rf_read_data1),
        .i_wr_en   (w_wr_en),
        .i_wr_reg  (bus.wb_reg),
        .i_wr_data (bus.wb_data),
        .o_operand (w_op_a)
    );

    operand_bypass #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_byp_b (
        .i_idx     (r_rt),
        .i_rf_data (bus.rf_read_data2),
        .i_wr_en   (w_wr_en),
        .i_wr_reg  (bus.wb_reg),
        .i_wr_data (bus.wb_data),
        .o_operand (w_op_b)
    );

    // Read FSM: latch indexes, snapshot operands one cycle later, hold until taken
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op_valid <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_rs    <= bus.rd_rs;
                        r_rt    <= bus.rd_rt;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_op_a     <= w_op_a;
                    r_op_b     <= w_op_b;
                    r_op_valid <= 1'b1;
                    r_state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.op_ready) begin
                        r_op_valid <= 1'b0;
                        if (w_accept) begin
                            r_rs    <= bus.rd_rs;
                            r_rt    <= bus.rd_rt;
                            r_state <= ST_READ;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_op_valid <= 1'b0;
                end
            endcase
        end
    end

    // Rejected r0 writes: one-cycle flag and a saturating tally
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_err <= w_r0_write;
            if (w_r0_write) begin
                r_cnt <= sat_inc(r_cnt);
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Randomized plus directed bench for regfile_port_ctrl with a queue scoreboard.
module tb_regfile_port_ctrl;

    logic clock;
    logic reset;

    regfile_port_ctrl_if bus ();

    regfile_port_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment register file: combinational read, write on rising edge
    logic [31:0] rf_mem [32];
    assign bus.rf_read_data1 = rf_mem[bus.rf_read_reg1];
    assign bus.rf_read_data2 = rf_mem[bus.rf_read_reg2];
    always @(posedge clock) begin
        if (bus.rf_RegWrite === 1'b1) rf_mem[bus.rf_write_reg] <= bus.rf_write_data;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: architectural register contents and transaction status
    logic [31:0] ref_rf [32];
    logic        m_pend;
    logic        m_out;
    logic [4:0]  m_rs;
    logic [4:0]  m_rt;
    logic        m_err;
    int          m_cnt;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_val(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : ref_rf[i];
    endfunction

    // One clock cycle of stimulus, control checks and model advance
    task automatic cycle(input logic rst_i, input logic rv, input logic [4:0] rs,
                         input logic [4:0] rt, input logic ordy, input logic wv,
                         input logic [4:0] wr, input logic [31:0] wd);
        logic exp_ready;
        exp_t e;
        @(posedge clock);
        #1;
        reset            = rst_i;
        bus.rd_req_valid = rv;
        bus.rd_rs        = rs;
        bus.rd_rt        = rt;
        bus.op_ready     = ordy;
        bus.wb_valid     = wv;
        bus.wb_reg       = wr;
        bus.wb_data      = wd;
        exp_ready = !m_pend && (!m_out || ordy);
        @(negedge clock);
        check("rd_req_ready", 64'(bus.rd_req_ready), 64'(exp_ready));
        check("op_valid", 64'(bus.op_valid), 64'(m_out));
        check("rf_RegWrite", 64'(bus.rf_RegWrite), 64'(wv && (wr != 5'd0)));
        check("rf_write_reg", 64'(bus.rf_write_reg), 64'(wr));
        check("rf_write_data", 64'(bus.rf_write_data), 64'(wd));
        check("rf_read_reg1", 64'(bus.rf_read_reg1), 64'(m_rs));
        check("rf_read_reg2", 64'(bus.rf_read_reg2), 64'(m_rt));
        check("err_r0_write", 64'(bus.err_r0_write), 64'(m_err));
        check("err_r0_count", 64'(bus.err_r0_count), 64'(m_cnt));
        // A write this cycle is visible to an operand sampled this cycle
        if (wv && (wr != 5'd0)) ref_rf[wr] = wd;
        if (rst_i) begin
            m_pend = 1'b0;
            m_out  = 1'b0;
            m_rs   = 5'd0;
            m_rt   = 5'd0;
            m_err  = 1'b0;
            m_cnt  = 0;
            exp_q.delete();
        end else begin
            m_err = wv && (wr == 5'd0);
            if (m_err && (m_cnt < 255)) m_cnt++;
            if (m_pend) begin
                e.a = reg_val(m_rs);
                e.b = reg_val(m_rt);
                exp_q.push_back(e);
                m_pend = 1'b0;
                m_out  = 1'b1;
            end else if (m_out && ordy) begin
                m_out = 1'b0;
            end
            if (rv && exp_ready) begin
                m_pend = 1'b1;
                m_rs   = rs;
                m_rt   = rt;
            end
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, ordy, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, r, d);
    endtask

    // Monitor: pop expected operands on every handshake, check stability while stalled
    initial begin : monitor
        logic        prev_hold;
        logic [31:0] pa;
        logic [31:0] pb;
        exp_t        e;
        prev_hold = 1'b0;
        pa = '0;
        pb = '0;
        forever begin
            @(negedge clock);
            if (prev_hold) begin
                check("hold_valid", 64'(bus.op_valid), 64'(1'b1));
                check("hold_op_a", 64'(bus.op_a), 64'(pa));
                check("hold_op_b", 64'(bus.op_b), 64'(pb));
            end
            if (reset !== 1'b1 && bus.op_valid === 1'b1 && bus.op_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_op: got op_a=%0h op_b=%0h with no expected entry", bus.op_a, bus.op_b);
                end else begin
                    e = exp_q.pop_front();
                    check("op_a", 64'(bus.op_a), 64'(e.a));
                    check("op_b", 64'(bus.op_b), 64'(e.b));
                end
            end
            prev_hold = (reset !== 1'b1) && (bus.op_valid === 1'b1) && (bus.op_ready === 1'b0);
            pa = bus.op_a;
            pb = bus.op_b;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        reset            = 1'b1;
        bus.rd_req_valid = 1'b0;
        bus.rd_rs        = '0;
        bus.rd_rt        = '0;
        bus.op_ready     = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_reg       = '0;
        bus.wb_data      = '0;
        m_pend = 1'b0;
        m_out  = 1'b0;
        m_rs   = 5'd0;
        m_rt   = 5'd0;
        m_err  = 1'b0;
        m_cnt  = 0;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = $urandom;
            ref_rf[i] = rf_mem[i];
        end

        // Reset state
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        idle(1'b0);
        check("rst_op_a", 64'(bus.op_a), 64'd0);
        check("rst_op_b", 64'(bus.op_b), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Basic read
        wb(5'd2, 32'd3);
        wb(5'd3, 32'd3);
        cycle(1'b0, 1'b1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 32'd0);
        idle(1'b1);
        idle(1'b1);

        // Forwarding of a write issued during the sampling cycle
        cycle(1'b0, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 32'h55);
        idle(1'b1);

        // r0 write rejected, then r0 reads as zero
        wb(5'd0, 32'd7);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        idle(1'b1);
        idle(1'b1);

        // Backpressure with a write to the held register
        wb(5'd5, 32'h11);
        cycle(1'b0, 1'b1, 5'd1, 5'd5, 1'b0, 1'b0, 5'd0, 32'd0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 5'd7, 5'd7, 1'b0, (i == 2), 5'd5, 32'd9);
        end
        idle(1'b1);

        // Back-to-back requests without an idle cycle
        cycle(1'b0, 1'b1, 5'd2, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0);
        idle(1'b0);
        cycle(1'b0, 1'b1, 5'd5, 5'd4, 1'b1, 1'b0, 5'd0, 32'd0);
        idle(1'b0);
        idle(1'b1);

        // Reset while sampling discards the request
        cycle(1'b0, 1'b1, 5'd2, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        idle(1'b1);
        idle(1'b1);

        // Counter saturation
        for (int i = 0; i < 300; i++) wb(5'd0, 32'd7);
        idle(1'b1);
        check("err_count_sat", 64'(bus.err_r0_count), 64'd255);

        for (int i = 0; i < 4; i++) idle(1'b1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
